// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer: opcodes, functs,
// ALU selector encodings and FSM state codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StTrap   = 3'd5;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode/funct; also flags whether an
// R-type funct is one the core supports.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_sel_o,
    output logic       funct_legal_o
);

    always_comb begin
        alu_sel_o     = AluAdd;
        funct_legal_o = 1'b0;
        case (opcode_i)
            OpRtype: begin
                funct_legal_o = 1'b1;
                case (funct_i)
                    FnAdd:   alu_sel_o = AluAdd;
                    FnSub:   alu_sel_o = AluSub;
                    FnAnd:   alu_sel_o = AluAnd;
                    FnOr:    alu_sel_o = AluOr;
                    FnSlt:   alu_sel_o = AluSlt;
                    default: funct_legal_o = 1'b0;
                endcase
            end
            OpBeq:   alu_sel_o = AluSub;
            default: alu_sel_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle Moore control FSM for the MIPS data path: latches the instruction,
// sequences FETCH/DECODE/EXEC/MEM/WB and parks unsupported opcodes in TRAP.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    output logic               MemaReg,
    output logic               enWrSram,
    output logic [2:0]         ALUSelector,
    output logic               enWriteMemory,
    output logic               ftePC,
    output logic               enablePC,
    output logic               fteALU,
    output logic               regDst,
    output logic               illegal,
    output logic [CNT_W-1:0]   instret
);

    logic [2:0]         state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic               zero_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   instret_q;

    logic [5:0] opcode, funct;
    logic [2:0] alu_sel;
    logic       funct_legal;
    logic       is_r, is_addi, is_lw, is_sw, is_beq, legal, in_ex;
    logic       unused_ir;

    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign unused_ir = ^ir_q[25:6];

    alu_decoder u_alu_decoder (
        .opcode_i      (opcode),
        .funct_i       (funct),
        .alu_sel_o     (alu_sel),
        .funct_legal_o (funct_legal)
    );

    assign is_r    = (opcode == OpRtype);
    assign is_addi = (opcode == OpAddi);
    assign is_lw   = (opcode == OpLw);
    assign is_sw   = (opcode == OpSw);
    assign is_beq  = (opcode == OpBeq);
    assign legal   = (is_r && funct_legal) || is_addi || is_lw || is_sw || is_beq;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (run) state_d = StDecode;
            StDecode: state_d = legal ? StExec : StTrap;
            StExec:   state_d = (is_lw || is_sw) ? StMem : StWb;
            StMem:    state_d = StWb;
            StWb:     state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch && run) ir_q <= instr;
            if (state_q == StExec) zero_q <= zero;
            if (state_q == StDecode && !legal) illegal_q <= 1'b1;
            if (state_q == StWb) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Outputs depend only on registered state so no input reaches them combinationally.
    assign in_ex = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

    always_comb begin
        MemaReg       = 1'b0;
        enWrSram      = 1'b0;
        ALUSelector   = AluAdd;
        enWriteMemory = 1'b0;
        ftePC         = 1'b0;
        enablePC      = 1'b0;
        fteALU        = 1'b0;
        regDst        = 1'b0;
        if (in_ex) begin
            ALUSelector = alu_sel;
            fteALU      = is_addi || is_lw || is_sw;
            regDst      = is_r;
        end
        if (state_q == StMem) begin
            enWriteMemory = is_sw;
            MemaReg       = is_lw;
        end
        if (state_q == StWb) begin
            enWrSram = is_r || is_addi || is_lw;
            MemaReg  = is_lw;
            ftePC    = is_beq && zero_q;
            enablePC = 1'b1;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Scoreboard bench: driver pushes per-cycle expected control vectors from an
// instruction-level reference model; a negedge monitor pops and compares.
module tb_mips_control_unit;

    logic        clk = 1'b0;
    logic        rst, run, zero;
    logic [31:0] instr;
    logic        MemaReg, enWrSram, enWriteMemory, ftePC, enablePC, fteALU, regDst, illegal;
    logic [2:0]  ALUSelector;
    logic [31:0] instret;

    mips_control_unit #(.INSTR_W(32), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .instr         (instr),
        .zero          (zero),
        .MemaReg       (MemaReg),
        .enWrSram      (enWrSram),
        .ALUSelector   (ALUSelector),
        .enWriteMemory (enWriteMemory),
        .ftePC         (ftePC),
        .enablePC      (enablePC),
        .fteALU        (fteALU),
        .regDst        (regDst),
        .illegal       (illegal),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] ctl;
        logic [31:0] cnt;
        int          stage;
        logic [31:0] iw;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_instret = 0;
    logic        m_illegal = 1'b0;
    logic        m_zq = 1'b0;

    // Instruction class: 0 add,1 sub,2 and,3 or,4 slt,5 addi,6 lw,7 sw,8 beq,-1 illegal
    function automatic int cls(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'h00: case (fn)
                6'h20: return 0;
                6'h22: return 1;
                6'h24: return 2;
                6'h25: return 3;
                6'h2A: return 4;
                default: return -1;
            endcase
            6'h08: return 5;
            6'h23: return 6;
            6'h2B: return 7;
            6'h04: return 8;
            default: return -1;
        endcase
    endfunction

    // Stages: 0 fetch, 1 decode, 2 exec, 3 mem, 4 wb, 5 trap, 6 reset
    function automatic exp_t ref_vec(input int stage, input logic [31:0] w);
        exp_t e;
        int k;
        logic [2:0] alu;
        logic mr, wr, wm, fp, ep, fa, rd;
        k   = cls(w);
        alu = (k >= 0 && k < 5) ? 3'(k) : (k == 8 ? 3'b001 : 3'b000);
        {mr, wr, wm, fp, ep, fa, rd} = '0;
        if (stage >= 2 && stage <= 4) begin
            fa = (k == 5 || k == 6 || k == 7);
            rd = (k >= 0 && k < 5);
        end else begin
            alu = 3'b000;
        end
        if (stage == 3) begin
            wm = (k == 7);
            mr = (k == 6);
        end
        if (stage == 4) begin
            wr = (k >= 0 && k <= 6);
            mr = (k == 6);
            fp = (k == 8) && m_zq;
            ep = 1'b1;
        end
        e.ctl   = {m_illegal, mr, wr, alu, wm, fp, ep, fa, rd};
        e.cnt   = m_instret;
        e.stage = stage;
        e.iw    = w;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [42:0] got;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {illegal, MemaReg, enWrSram, ALUSelector, enWriteMemory, ftePC, enablePC,
                   fteALU, regDst, instret};
            n_vec++;
            if (got !== {e.ctl, e.cnt}) begin
                n_bad++;
                $display("FAIL ctl stage=%0d instr=%h got=%h exp=%h", e.stage, e.iw, got,
                         {e.ctl, e.cnt});
            end
        end
    end

    task automatic cyc(input logic r, input logic [31:0] w, input logic z, input int stage,
                       input logic [31:0] iw);
        @(posedge clk);
        #1;
        run   = r;
        instr = w;
        zero  = z;
        sb.push_back(ref_vec(stage, iw));
    endtask

    // Reset asserted mid-cycle; the monitor samples while it is held.
    task automatic reset_cycle();
        @(posedge clk);
        #1;
        run       = 1'b0;
        m_instret = 0;
        m_illegal = 1'b0;
        m_zq      = 1'b0;
        sb.push_back(ref_vec(6, 32'h0));
        #2 rst = 1'b1;
        #4 rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input logic z, input int idle,
                         input bit rst_in_mem);
        int k;
        k = cls(w);
        for (int i = 0; i < idle; i++) cyc(1'b0, $urandom, 1'($urandom), 0, 32'h0);
        cyc(1'b1, w, 1'($urandom), 0, w);
        cyc(1'($urandom), $urandom, 1'($urandom), 1, w);
        if (k < 0) begin
            m_illegal = 1'b1;
            for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'($urandom), 5, w);
            reset_cycle();
            return;
        end
        cyc(1'($urandom), $urandom, z, 2, w);
        m_zq = z;
        if (k == 6 || k == 7) begin
            if (rst_in_mem) begin
                reset_cycle();
                return;
            end
            cyc(1'($urandom), $urandom, 1'($urandom), 3, w);
        end
        cyc(1'($urandom), $urandom, 1'($urandom), 4, w);
        m_instret++;
    endtask

    function automatic logic [31:0] rand_instr(input bit want_illegal);
        logic [31:0] w;
        logic [5:0] ops [4];
        logic [5:0] fns [5];
        int k;
        ops = '{6'h08, 6'h23, 6'h2B, 6'h04};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        w = $urandom;
        if (want_illegal) begin
            while (cls(w) >= 0) w = $urandom;
            return w;
        end
        k = $urandom_range(0, 8);
        if (k < 5) begin
            w[31:26] = 6'h00;
            w[5:0]   = fns[k];
        end else begin
            w[31:26] = ops[k-5];
        end
        return w;
    endfunction

    initial begin
        rst   = 1'b1;
        run   = 1'b0;
        zero  = 1'b0;
        instr = 32'h0;
        #2 sb.push_back(ref_vec(6, 32'h0));
        #10 rst = 1'b0;
        issue(32'h012A4020, 1'b0, 0, 1'b0);
        issue(32'h8D090004, 1'b1, 0, 1'b0);
        issue(32'hAD090004, 1'b0, 1, 1'b0);
        issue(32'h11090003, 1'b1, 0, 1'b0);
        issue(32'h11090003, 1'b0, 5, 1'b0);
        issue(32'hAD090004, 1'b1, 0, 1'b1);
        issue(32'h012A4022, 1'b0, 0, 1'b0);
        issue(32'hFC000000, 1'b0, 0, 1'b0);
        issue(32'h01284000, 1'b0, 2, 1'b0);
        issue(32'h21090005, 1'b1, 0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            w = rand_instr($urandom_range(0, 15) == 0);
            issue(w, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                  $urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_control_unit.md
# mips_control_unit

Multicycle control sequencer for the 32-bit MIPS core; sits directly upstream of `data_path` and drives every one of its control inputs. It latches the current instruction word, decodes opcode/funct, and steps a Moore FSM through FETCH/DECODE/EXEC/MEM/WB. Each instruction ends with exactly one `enablePC` pulse. Unsupported opcodes park the core in a sticky trap.

## Interface
- `INSTR_W`, 32, instruction word width
- `CNT_W`, 32, retired-instruction counter width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `run`  in  1  1 = leave FETCH and start next instruction; 0 = hold in FETCH
- `instr`  in  INSTR_W  instruction word from program memory at current PC
- `zero`  in  1  ALU zero flag from `data_path`
- `MemaReg`  out  1  write-back source: 1 = data memory, 0 = ALU
- `enWrSram`  out  1  register-file write enable
- `ALUSelector`  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt
- `enWriteMemory`  out  1  data-memory write enable
- `ftePC`  out  1  PC source: 1 = branch target, 0 = PC+4
- `enablePC`  out  1  PC update strobe
- `fteALU`  out  1  ALU B source: 1 = sign-extended immediate, 0 = rt
- `regDst`  out  1  destination: 1 = rd, 0 = rt
- `illegal`  out  1  sticky unsupported-instruction flag
- `instret`  out  CNT_W  retired-instruction count

## Operation
- Supported instructions:
  - R-type, opcode 0x00: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - Any other opcode or funct is illegal.
- `ir_q` captures `instr` on the FETCH→DECODE transition. All decoding uses `ir_q` only.
- FSM states and transitions:
  - FETCH: → DECODE if `run`=1, else stay.
  - DECODE: → TRAP if illegal, else → EXEC.
  - EXEC: → MEM for lw/sw, else → WB. `zero_q` captures `zero` at the end of EXEC.
  - MEM: → WB.
  - WB: → FETCH. `instret` increments by 1 and wraps at 2^CNT_W.
  - TRAP: stays in TRAP until `rst`.
- Outputs are Moore: decoded from the state register, `ir_q` and `zero_q` only. There is no combinational path from `instr`/`zero`/`run` to any output.
- FETCH, DECODE and TRAP drive every control output to 0.
- EXEC, MEM and WB hold these stable:
  - `ALUSelector`: funct map for R-type; add for addi/lw/sw; sub for beq.
  - `fteALU` = 1 for addi/lw/sw.
  - `regDst` = 1 for R-type.
- MEM:
  - `enWriteMemory` = 1 for sw only.
  - `MemaReg` = 1 for lw.
- WB:
  - `enWrSram` = 1 for R-type, addi, lw.
  - `MemaReg` = 1 for lw.
  - `ftePC` = beq AND `zero_q`.
  - `enablePC` = 1 for every instruction.
- `illegal` goes to 1 on the DECODE→TRAP transition and stays 1 until reset.

## Timing
- Reset (asynchronous, immediate):
  - State = FETCH.
  - `ir_q`, `zero_q`, `instret` = 0.
  - All outputs = 0, including `illegal`.
- Latency, counted from the first FETCH cycle with `run`=1:
  - R-type, addi, beq: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw, sw: 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
- Single-cycle pulses:
  - `enablePC`: exactly one cycle per retired instruction.
  - `enWrSram`: at most one cycle per instruction.
  - `enWriteMemory`: at most one cycle per instruction.
- `instret` updates on the same edge that leaves WB.
- `run` is sampled only in FETCH. Deasserting it later does not abort the instruction in flight.
- `instr` must be stable during the FETCH cycle in which `run`=1. Later changes have no effect.
- If `rst` asserts mid-instruction (any state), the instruction is abandoned:
  - No further write strobes are issued.
  - `instret` does not count it.
- An illegal instruction never asserts `enablePC`, `enWrSram` or `enWriteMemory`.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - Opcode constants.
  - Funct constants.
  - `ALUSelector` encodings.
  - State enum (FETCH, DECODE, EXEC, MEM, WB, TRAP).
- One sub-module, `alu_decoder`: combinational (opcode, funct) → (`ALUSelector`, funct_legal).
- FSM, `ir_q`, `zero_q` and `instret` live in `mips_control_unit`.

## Test plan
- add, `instr`=0x012A4020, `run`=1 → `enablePC` pulses 4 cycles after FETCH. In EXEC..WB: `ALUSelector`=000, `regDst`=1, `fteALU`=0. `enWrSram`=1 only in WB. `instret`=1.
- lw, `instr`=0x8D090004 → 5-cycle sequence; MEM and WB have `MemaReg`=1 and `fteALU`=1; `enWrSram` pulses in WB. sw, `instr`=0xAD090004 → `enWriteMemory` pulses in MEM only; `enWrSram` stays 0.
- beq, `instr`=0x11090003:
  - `zero`=1 in EXEC → `ftePC`=1 with `enablePC` in WB; `ALUSelector`=001.
  - `zero`=0 → `ftePC`=0.
- `run`=0 for 5 cycles → FSM stays in FETCH; all outputs 0; `instret` unchanged.
- opcode 0x3F, or R-type funct 0x00 → TRAP after DECODE. `illegal`=1 and stays 1. No `enablePC` pulse, even with `run`=1 for 10 cycles.
- `rst` asserted in MEM of sw → outputs 0 immediately; `enWriteMemory` ends immediately; state = FETCH; `instret`=0; next instruction runs normally.
